// File: rtl/mem_pkg.sv
// Shared constants for the memory port arbiter.
// State encoding and default widths.
package mem_pkg;
  localparam int DEF_ADDR_W   = 13;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_MAX_LOCK = 4;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_ACCESS = 2'd1;
  localparam state_t S_ACK    = 2'd2;
endpackage

// File: rtl/arb_lock_counter.sv
// Grant decision for two ports: round-robin with a
// bounded lock that lets the last owner keep the memory.
module arb_lock_counter
  import mem_pkg::*;
#(
  parameter int MAX_LOCK = DEF_MAX_LOCK
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic [1:0] lock_i,
  input  logic       last_i,
  input  logic       take_i,
  output logic       gnt_id_o,
  output logic       gnt_vld_o
);
  localparam int CW = $clog2(MAX_LOCK + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          keep;

  always_comb begin
    keep = lock_i[last_i] && req_i[last_i]
        && (cnt_q < CW'(MAX_LOCK));
    gnt_vld_o = |req_i;
    if (req_i == 2'b11) begin
      gnt_id_o = keep ? last_i : ~last_i;
    end else begin
      gnt_id_o = req_i[1];
    end
    // re-grant under lock counts up; anything else restarts the run
    if (gnt_id_o == last_i && lock_i[gnt_id_o]) begin
      cnt_d = (cnt_q < CW'(MAX_LOCK)) ? cnt_q + CW'(1) : cnt_q;
    end else begin
      cnt_d = CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (take_i && gnt_vld_o) begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-port memory.
// Fixed IDLE/ACCESS/ACK cycle per access.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_LOCK = DEF_MAX_LOCK
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              owner,
  output logic [ADDR_W-1:0] memAddress,
  output logic [DATA_W-1:0] memInData,
  output logic              memWriteEn,
  input  logic [DATA_W-1:0] memOutData
);
  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              gnt_id, gnt_vld;

  arb_lock_counter #(
    .MAX_LOCK(MAX_LOCK)
  ) u_lock (
    .clk      (clk),
    .rst      (rst),
    .req_i    ({req1, req0}),
    .lock_i   ({lock1, lock0}),
    .last_i   (owner_q),
    .take_i   (state_q == S_IDLE),
    .gnt_id_o (gnt_id),
    .gnt_vld_o(gnt_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          state_d = S_ACCESS;
          owner_d = gnt_id;
        end
      end
      S_ACCESS: begin
        state_d = S_ACK;
        rdata_d = memOutData;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    memAddress = '0;
    memInData  = '0;
    memWriteEn = 1'b0;
    ack0       = 1'b0;
    ack1       = 1'b0;
    if (state_q == S_ACCESS) begin
      memAddress = owner_q ? addr1 : addr0;
      memInData  = owner_q ? wdata1 : wdata0;
      // a write never commits during a reset cycle
      memWriteEn = (owner_q ? we1 : we0) & ~rst;
    end
    if (state_q == S_ACK) begin
      ack0 = ~owner_q;
      ack1 = owner_q;
    end
  end

  assign rdata = rdata_q;
  assign owner = owner_q;
endmodule
